// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_pkg
// Brief    : Response codes, register offsets, FSM states and address decode
//            shared by the AXI-Lite register slaves.
// Revision : 1.0 - initial release
// ============================================================================
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    localparam logic [3:0] REG0_OFF    = 4'h0;
    localparam logic [3:0] REG1_OFF    = 4'h4;
    localparam logic [3:0] WR_CNT_OFF  = 4'h8;
    localparam logic [3:0] ERR_CNT_OFF = 4'hC;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    typedef struct packed {
        logic       rd_ok;
        logic       wr_ok;
        logic [1:0] idx;
    } dec_t;

    // The base is 16-byte aligned, so the upper address bits select the bank.
    function automatic dec_t decode_addr(input logic [31:0] addr, input logic [31:0] base);
        dec_t       d;
        logic [3:0] off;
        off     = addr[3:0] - base[3:0];
        d.idx   = off[3:2];
        d.rd_ok = (addr[31:4] == base[31:4]) && (off[1:0] == 2'b00);
        d.wr_ok = d.rd_ok && ((off == REG0_OFF) || (off == REG1_OFF));
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_lite_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_reg_slave
// Brief    : AXI-Lite responder with two RW registers, a write counter and an
//            error counter; independent write and read channel FSMs.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_reg_slave
    import axi_lite_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 3,
    parameter int BASE_ADDR  = 0
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8:0]   s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [RESP_WIDTH-1:0]   s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [RESP_WIDTH-1:0]   s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    // Register bank
    logic [DATA_WIDTH-1:0]  r_reg0;
    logic [DATA_WIDTH-1:0]  r_reg1;
    logic [DATA_WIDTH-1:0]  r_wr_cnt;
    logic [DATA_WIDTH-1:0]  r_err_cnt;

    // Write channel
    wr_state_t              r_wr_state;
    wr_state_t              w_wr_state_nxt;
    logic                   r_aw_done;
    logic                   r_w_done;
    logic                   w_aw_done_nxt;
    logic                   w_w_done_nxt;
    logic                   r_awready;
    logic                   r_wready;
    logic                   w_awready_nxt;
    logic                   w_wready_nxt;
    logic                   r_bvalid;
    logic                   w_bvalid_nxt;
    logic [RESP_WIDTH-1:0]  r_bresp;
    logic [RESP_WIDTH-1:0]  w_bresp_nxt;
    logic [ADDR_WIDTH-1:0]  r_awaddr;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [STRB_WIDTH-1:0]  r_wstrb;
    logic                   w_aw_hs;
    logic                   w_w_hs;
    logic                   w_wr_commit;
    logic                   w_wr_err;
    dec_t                   w_wr_dec;
    logic [DATA_WIDTH-1:0]  w_wr_old;
    logic [DATA_WIDTH-1:0]  w_wr_merged;

    // Read channel
    rd_state_t              r_rd_state;
    rd_state_t              w_rd_state_nxt;
    logic                   r_arready;
    logic                   w_arready_nxt;
    logic                   r_rvalid;
    logic                   w_rvalid_nxt;
    logic [DATA_WIDTH-1:0]  r_rdata;
    logic [DATA_WIDTH-1:0]  w_rdata_nxt;
    logic [RESP_WIDTH-1:0]  r_rresp;
    logic [RESP_WIDTH-1:0]  w_rresp_nxt;
    logic                   w_ar_hs;
    logic                   w_rd_err;
    dec_t                   w_rd_dec;
    logic [DATA_WIDTH-1:0]  w_rd_val;

    logic [1:0]             w_err_inc;
    logic                   w_unused_ok;

    assign w_aw_hs  = s_axi_awvalid & r_awready;
    assign w_w_hs   = s_axi_wvalid  & r_wready;
    assign w_ar_hs  = s_axi_arvalid & r_arready;

    assign w_wr_dec = decode_addr(32'(r_awaddr), 32'(BASE_ADDR));
    assign w_rd_dec = decode_addr(32'(s_axi_araddr), 32'(BASE_ADDR));

    assign w_unused_ok = &{1'b0, s_axi_wstrb[STRB_WIDTH], w_wr_dec.rd_ok, w_rd_dec.wr_ok};

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_wr_state <= W_IDLE;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= '0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_aw_done  <= w_aw_done_nxt;
            r_w_done   <= w_w_done_nxt;
            r_awready  <= w_awready_nxt;
            r_wready   <= w_wready_nxt;
            r_bvalid   <= w_bvalid_nxt;
            r_bresp    <= w_bresp_nxt;
        end
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_aw_done_nxt  = r_aw_done;
        w_w_done_nxt   = r_w_done;
        w_bvalid_nxt   = r_bvalid;
        w_bresp_nxt    = r_bresp;
        w_wr_commit    = 1'b0;
        case (r_wr_state)
            W_IDLE: begin
                // Commit one cycle after both channels have been captured.
                if (r_aw_done && r_w_done) begin
                    w_wr_commit    = 1'b1;
                    w_wr_state_nxt = W_RESP;
                    w_aw_done_nxt  = 1'b0;
                    w_w_done_nxt   = 1'b0;
                    w_bvalid_nxt   = 1'b1;
                    w_bresp_nxt    = w_wr_dec.wr_ok ? RESP_WIDTH'(RESP_OKAY)
                                                    : RESP_WIDTH'(RESP_SLVERR);
                end else begin
                    if (w_aw_hs) begin
                        w_aw_done_nxt = 1'b1;
                    end
                    if (w_w_hs) begin
                        w_w_done_nxt = 1'b1;
                    end
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    w_bvalid_nxt   = 1'b0;
                    w_wr_state_nxt = W_IDLE;
                end
            end
            default: begin
                w_wr_state_nxt = W_IDLE;
            end
        endcase
        w_awready_nxt = (w_wr_state_nxt == W_IDLE) && !w_aw_done_nxt;
        w_wready_nxt  = (w_wr_state_nxt == W_IDLE) && !w_w_done_nxt;
    end

    assign w_wr_err = w_wr_commit && !w_wr_dec.wr_ok;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
        end else begin
            if (w_aw_hs) begin
                r_awaddr <= s_axi_awaddr;
            end
            if (w_w_hs) begin
                r_wdata <= s_axi_wdata;
                r_wstrb <= s_axi_wstrb[STRB_WIDTH-1:0];
            end
        end
    end

    assign w_wr_old = w_wr_dec.idx[0] ? r_reg1 : r_reg0;

    always_comb begin
        w_wr_merged = w_wr_old;
        for (int i = 0; i < STRB_WIDTH; i++) begin
            if (r_wstrb[i]) begin
                w_wr_merged[8*i +: 8] = r_wdata[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_rd_state <= R_IDLE;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= '0;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            r_arready  <= w_arready_nxt;
            r_rvalid   <= w_rvalid_nxt;
            r_rdata    <= w_rdata_nxt;
            r_rresp    <= w_rresp_nxt;
        end
    end

    always_comb begin
        w_rd_val = '0;
        case ({w_rd_dec.idx, 2'b00})
            REG0_OFF:    w_rd_val = r_reg0;
            REG1_OFF:    w_rd_val = r_reg1;
            WR_CNT_OFF:  w_rd_val = r_wr_cnt;
            ERR_CNT_OFF: w_rd_val = r_err_cnt;
            default:     w_rd_val = '0;
        endcase
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_rvalid_nxt   = r_rvalid;
        w_rdata_nxt    = r_rdata;
        w_rresp_nxt    = r_rresp;
        w_rd_err       = 1'b0;
        case (r_rd_state)
            R_IDLE: begin
                if (w_ar_hs) begin
                    w_rd_state_nxt = R_DATA;
                    w_rvalid_nxt   = 1'b1;
                    w_rdata_nxt    = w_rd_dec.rd_ok ? w_rd_val : '0;
                    w_rresp_nxt    = w_rd_dec.rd_ok ? RESP_WIDTH'(RESP_OKAY)
                                                    : RESP_WIDTH'(RESP_SLVERR);
                    w_rd_err       = !w_rd_dec.rd_ok;
                end
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    w_rvalid_nxt   = 1'b0;
                    w_rd_state_nxt = R_IDLE;
                end
            end
            default: begin
                w_rd_state_nxt = R_IDLE;
            end
        endcase
        w_arready_nxt = (w_rd_state_nxt == R_IDLE);
    end

    // ------------------------------------------------------------------
    // Register bank and counters
    // ------------------------------------------------------------------
    assign w_err_inc = {1'b0, w_wr_err} + {1'b0, w_rd_err};

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_reg0    <= '0;
            r_reg1    <= '0;
            r_wr_cnt  <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_wr_commit && w_wr_dec.wr_ok) begin
                if (w_wr_dec.idx[0]) begin
                    r_reg1 <= w_wr_merged;
                end else begin
                    r_reg0 <= w_wr_merged;
                end
                r_wr_cnt <= r_wr_cnt + DATA_WIDTH'(1);
            end
            // Read and write errors on the same edge both count.
            r_err_cnt <= r_err_cnt + DATA_WIDTH'(w_err_inc);
        end
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_reg_slave
// Brief    : Self-checking bench for axi_lite_reg_slave (BASE_ADDR = 16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_reg_slave;

    localparam int BASE = 16;

    logic        clk;
    logic        rst_n;
    logic [7:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [4:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [2:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [7:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [2:0]  rresp;
    logic        rvalid;
    logic        rready;

    int          vectors;
    int          miscompares;

    logic [31:0] m_reg [2];
    logic [31:0] m_wr_cnt;
    logic [31:0] m_err_cnt;

    axi_lite_reg_slave #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (8),
        .RESP_WIDTH (3),
        .BASE_ADDR  (BASE)
    ) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .s_axi_awaddr  (awaddr),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit m_legal(input int addr, input bit is_wr);
        int off;
        off = addr - BASE;
        if (off < 0 || off > 15 || (off % 4) != 0) return 1'b0;
        if (is_wr && off >= 8) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [2:0] m_resp(input int addr, input bit is_wr);
        return m_legal(addr, is_wr) ? 3'd0 : 3'd2;
    endfunction

    function automatic logic [31:0] m_read_val(input int addr);
        if (!m_legal(addr, 1'b0)) return 32'h0;
        case ((addr - BASE) / 4)
            0:       return m_reg[0];
            1:       return m_reg[1];
            2:       return m_wr_cnt;
            default: return m_err_cnt;
        endcase
    endfunction

    task automatic m_write(input int addr, input logic [31:0] d, input logic [4:0] s);
        int idx;
        if (m_legal(addr, 1'b1)) begin
            idx = (addr - BASE) / 4;
            for (int b = 0; b < 4; b++) begin
                if (s[b]) m_reg[idx][8*b +: 8] = d[8*b +: 8];
            end
            m_wr_cnt = m_wr_cnt + 1;
        end else begin
            m_err_cnt = m_err_cnt + 1;
        end
    endtask

    task automatic m_read(input int addr);
        if (!m_legal(addr, 1'b0)) m_err_cnt = m_err_cnt + 1;
    endtask

    task automatic m_reset();
        m_reg[0]  = 32'h0;
        m_reg[1]  = 32'h0;
        m_wr_cnt  = 32'h0;
        m_err_cnt = 32'h0;
    endtask

    // ---------------- bus drivers ----------------
    task automatic aw_w_phase(input logic [7:0] a, input logic [31:0] d, input logic [4:0] s);
        bit aw_p, w_p, hs_aw, hs_w;
        int n;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        aw_p = 1'b1; w_p = 1'b1; n = 0;
        while ((aw_p || w_p) && n < 50) begin
            @(negedge clk);
            hs_aw = aw_p && awready;
            hs_w  = w_p && wready;
            @(posedge clk); #1;
            if (hs_aw) begin aw_p = 1'b0; awvalid = 1'b0; end
            if (hs_w)  begin w_p = 1'b0;  wvalid = 1'b0;  end
            n++;
        end
        if (aw_p || w_p) begin
            vectors++; miscompares++;
            $display("FAIL aw_w_timeout: aw_pending=%0d w_pending=%0d required 0 0", aw_p, w_p);
            awvalid = 1'b0; wvalid = 1'b0;
        end
    endtask

    task automatic wait_b(output logic [2:0] resp, output int lat);
        lat = 0;
        while (!bvalid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        resp = bresp;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic drive_write(input logic [7:0] a, input logic [31:0] d, input logic [4:0] s,
                               output logic [2:0] resp, output int lat);
        aw_w_phase(a, d, s);
        wait_b(resp, lat);
    endtask

    task automatic drive_read(input logic [7:0] a, output logic [31:0] data,
                              output logic [2:0] resp, output int lat);
        bit hs, pend;
        int n;
        araddr = a; arvalid = 1'b1; pend = 1'b1; n = 0;
        while (pend && n < 50) begin
            @(negedge clk);
            hs = arready;
            @(posedge clk); #1;
            if (hs) begin pend = 1'b0; arvalid = 1'b0; end
            n++;
        end
        arvalid = 1'b0;
        lat = pend ? 99 : 0;
        while (!pend && !rvalid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        data = rdata;
        resp = rresp;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_handshake: got %b required 00000", {awready, wready, arready, bvalid, rvalid});
        end
        vectors++;
        if ({bresp, rresp, rdata} !== 38'h0) begin
            miscompares++;
            $display("FAIL reset_resp_data: got bresp=%0h rresp=%0h rdata=%0h required 0", bresp, rresp, rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if ({awready, wready, arready} !== 3'b000) begin
            miscompares++;
            $display("FAIL ready_before_edge: got %b required 000", {awready, wready, arready});
        end
        @(posedge clk); #1;
        vectors++;
        if ({awready, wready, arready} !== 3'b111) begin
            miscompares++;
            $display("FAIL ready_after_edge: got %b required 111", {awready, wready, arready});
        end
    endtask

    task automatic test_basic();
        logic [2:0]  resp;
        logic [31:0] data;
        int          lat;
        drive_write(8'(BASE), 32'hDEADBEEF, 5'h0F, resp, lat);
        m_write(BASE, 32'hDEADBEEF, 5'h0F);
        vectors++;
        if (lat !== 1) begin miscompares++; $display("FAIL basic_b_latency: got %0d required 1", lat); end
        vectors++;
        if (resp !== m_resp(BASE, 1'b1)) begin miscompares++; $display("FAIL basic_bresp: got %0h required 0", resp); end
        drive_read(8'(BASE), data, resp, lat);
        vectors++;
        if (data !== m_read_val(BASE) || resp !== m_resp(BASE, 1'b0) || lat !== 0) begin
            miscompares++;
            $display("FAIL basic_read_reg0: got data=%h resp=%0h lat=%0d required data=%h resp=0 lat=0",
                     data, resp, lat, m_read_val(BASE));
        end
        m_read(BASE);
        drive_read(8'(BASE + 8), data, resp, lat);
        vectors++;
        if (data !== m_read_val(BASE + 8) || resp !== 3'd0) begin
            miscompares++;
            $display("FAIL basic_wr_cnt: got data=%h resp=%0h required data=%h resp=0", data, resp, m_read_val(BASE + 8));
        end
        m_read(BASE + 8);
    endtask

    task automatic test_w_before_aw();
        logic [2:0]  resp;
        logic [31:0] data;
        int          lat;
        bit          hs;
        wdata = 32'h12345678; wstrb = 5'h05; wvalid = 1'b1;
        @(negedge clk);
        hs = wready;
        @(posedge clk); #1;
        wvalid = 1'b0;
        vectors++;
        if (!hs) begin miscompares++; $display("FAIL early_w_accept: got wready=0 required 1"); end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({wready, bvalid, awready} !== 3'b001) begin
                miscompares++;
                $display("FAIL early_w_wait: got wready/bvalid/awready=%b required 001", {wready, bvalid, awready});
            end
            @(posedge clk); #1;
        end
        awaddr = 8'(BASE + 4); awvalid = 1'b1;
        hs = 1'b0;
        for (int n = 0; n < 50 && !hs; n++) begin
            @(negedge clk);
            hs = awready;
            @(posedge clk); #1;
        end
        awvalid = 1'b0;
        wait_b(resp, lat);
        m_write(BASE + 4, 32'h12345678, 5'h05);
        vectors++;
        if (lat !== 1 || resp !== 3'd0) begin
            miscompares++;
            $display("FAIL late_aw_b: got lat=%0d resp=%0h required lat=1 resp=0", lat, resp);
        end
        drive_read(8'(BASE + 4), data, resp, lat);
        vectors++;
        if (data !== m_read_val(BASE + 4)) begin
            miscompares++;
            $display("FAIL strobe_merge: got %h required %h", data, m_read_val(BASE + 4));
        end
        m_read(BASE + 4);
    endtask

    task automatic test_errors();
        logic [2:0]  resp;
        logic [31:0] data;
        int          lat;
        int          addrs [3];
        addrs[0] = BASE + 8; addrs[1] = BASE + 32; addrs[2] = BASE + 2;
        drive_write(8'(addrs[0]), 32'hFFFFFFFF, 5'h1F, resp, lat);
        m_write(addrs[0], 32'hFFFFFFFF, 5'h1F);
        vectors++;
        if (resp !== m_resp(addrs[0], 1'b1)) begin
            miscompares++; $display("FAIL ro_write_resp: got %0h required 2", resp);
        end
        for (int i = 1; i < 3; i++) begin
            drive_read(8'(addrs[i]), data, resp, lat);
            vectors++;
            if (resp !== m_resp(addrs[i], 1'b0) || data !== m_read_val(addrs[i])) begin
                miscompares++;
                $display("FAIL bad_read_%0d: got resp=%0h data=%h required resp=2 data=0", i, resp, data);
            end
            m_read(addrs[i]);
        end
        drive_read(8'(BASE + 12), data, resp, lat);
        vectors++;
        if (data !== m_read_val(BASE + 12)) begin
            miscompares++; $display("FAIL err_cnt: got %0d required %0d", data, m_read_val(BASE + 12));
        end
        drive_read(8'(BASE + 8), data, resp, lat);
        vectors++;
        if (data !== m_read_val(BASE + 8)) begin
            miscompares++; $display("FAIL wr_cnt_unchanged: got %0d required %0d", data, m_read_val(BASE + 8));
        end
    endtask

    task automatic test_b_backpressure();
        logic [2:0]  resp;
        logic [31:0] data;
        int          lat;
        bready = 1'b0;
        aw_w_phase(8'(BASE), 32'hCAFEF00D, 5'h0F);
        m_write(BASE, 32'hCAFEF00D, 5'h0F);
        awaddr = 8'(BASE + 4); awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vectors++;
            if ({bvalid, awready, wready} !== 3'b100 || bresp !== 3'd0) begin
                miscompares++;
                $display("FAIL b_hold: got bvalid/awready/wready=%b bresp=%0h required 100 0",
                         {bvalid, awready, wready}, bresp);
            end
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        vectors++;
        if (bvalid !== 1'b0 || awready !== 1'b1) begin
            miscompares++;
            $display("FAIL b_release: got bvalid=%b awready=%b required 0 1", bvalid, awready);
        end
        drive_write(8'(BASE + 4), 32'h0BADF00D, 5'h0F, resp, lat);
        m_write(BASE + 4, 32'h0BADF00D, 5'h0F);
        drive_read(8'(BASE + 4), data, resp, lat);
        vectors++;
        if (data !== m_read_val(BASE + 4)) begin
            miscompares++; $display("FAIL second_aw_write: got %h required %h", data, m_read_val(BASE + 4));
        end
    endtask

    task automatic test_same_cycle();
        logic [2:0]  resp;
        logic [31:0] data;
        logic [31:0] exp_old;
        int          lat;
        drive_write(8'(BASE), 32'hA, 5'h0F, resp, lat);
        m_write(BASE, 32'hA, 5'h0F);
        aw_w_phase(8'(BASE), 32'h1, 5'h0F);
        araddr = 8'(BASE); arvalid = 1'b1;
        exp_old = m_read_val(BASE);
        @(posedge clk); #1;
        arvalid = 1'b0;
        vectors++;
        if (rvalid !== 1'b1 || bvalid !== 1'b1 || rdata !== exp_old) begin
            miscompares++;
            $display("FAIL same_edge_read: got rvalid=%b bvalid=%b rdata=%h required 1 1 %h",
                     rvalid, bvalid, rdata, exp_old);
        end
        m_write(BASE, 32'h1, 5'h0F);
        m_read(BASE);
        rready = 1'b1; bready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0; bready = 1'b0;
        drive_read(8'(BASE), data, resp, lat);
        vectors++;
        if (data !== m_read_val(BASE)) begin
            miscompares++; $display("FAIL after_same_edge: got %h required %h", data, m_read_val(BASE));
        end
    endtask

    task automatic test_random();
        logic [2:0]  resp;
        logic [31:0] data;
        logic [31:0] d;
        logic [4:0]  s;
        int          lat;
        int          addr;
        int          sel;
        for (int i = 0; i < 60; i++) begin
            sel = int'($urandom_range(0, 6));
            if (sel < 4)       addr = BASE + 4 * sel;
            else if (sel == 4) addr = BASE + int'($urandom_range(0, 15));
            else               addr = int'($urandom_range(0, 255));
            d = $urandom;
            s = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) begin
                drive_write(8'(addr), d, s, resp, lat);
                vectors++;
                if (resp !== m_resp(addr, 1'b1) || lat !== 1) begin
                    miscompares++;
                    $display("FAIL rand_write addr=%0h: got resp=%0h lat=%0d required resp=%0h lat=1",
                             addr, resp, lat, m_resp(addr, 1'b1));
                end
                m_write(addr, d, s);
            end else begin
                drive_read(8'(addr), data, resp, lat);
                vectors++;
                if (resp !== m_resp(addr, 1'b0) || data !== m_read_val(addr)) begin
                    miscompares++;
                    $display("FAIL rand_read addr=%0h: got data=%h resp=%0h required data=%h resp=%0h",
                             addr, data, resp, m_read_val(addr), m_resp(addr, 1'b0));
                end
                m_read(addr);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [2:0]  resp;
        logic [31:0] data;
        int          lat;
        bready = 1'b0; rready = 1'b0;
        aw_w_phase(8'(BASE), $urandom, 5'h0F);
        araddr = 8'(BASE + 4); arvalid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        arvalid = 1'b0;
        vectors++;
        if ({bvalid, rvalid} !== 2'b11) begin
            miscompares++; $display("FAIL async_setup: got bvalid/rvalid=%b required 11", {bvalid, rvalid});
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bvalid, rvalid, awready, arready} !== 4'b0000) begin
            miscompares++;
            $display("FAIL async_assert: got bvalid/rvalid/awready/arready=%b required 0000",
                     {bvalid, rvalid, awready, arready});
        end
        m_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_read(8'(BASE + 4 * i), data, resp, lat);
            vectors++;
            if (data !== m_read_val(BASE + 4 * i) || resp !== 3'd0) begin
                miscompares++;
                $display("FAIL post_reset_reg%0d: got data=%h resp=%0h required 0 0", i, data, resp);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_w_before_aw();
        test_errors();
        test_b_backpressure();
        test_same_cycle();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
